// File: rtl/display_pkg.sv
// Shared types and the 7-segment lookup for display
// scan paths.
package display_pkg;

  typedef struct packed {
    logic       en;
    logic [3:0] digit;
    logic       dp_n;
  } disp_word_t;

  typedef enum logic {
    BLANK,
    DRIVE
  } scan_state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  // Active-low {g..a} pattern for a hex digit.
  function automatic logic [6:0] seg_n(
    input logic [3:0] d
  );
    logic [6:0] s;
    case (d)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex digit + point to active-low
// cathode pattern {dp, g..a}.
module seg7_decoder
  import display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       dp_n,
  output logic [7:0] cat
);

  assign cat = {dp_n, seg_n(digit)};

endmodule

// File: rtl/display_scan_driver.sv
// Eight-digit multiplexed common-anode scan with a
// blanking gap at the start of every digit slot.
module display_scan_driver
  import display_pkg::*;
#(
  parameter int unsigned SLOT_CYCLES  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] d1,
  input  logic [5:0] d2,
  input  logic [5:0] d3,
  input  logic [5:0] d4,
  input  logic [5:0] d5,
  input  logic [5:0] d6,
  input  logic [5:0] d7,
  input  logic [5:0] d8,
  output logic [7:0] an,
  output logic [7:0] dec_cat,
  output logic       frame_start
);

  if (BLANK_CYCLES < 1 ||
      BLANK_CYCLES >= SLOT_CYCLES) begin : g_bad
    $error("BLANK_CYCLES out of range");
  end

  localparam int CW = $clog2(SLOT_CYCLES);
  localparam logic [CW-1:0] SLOT_LAST =
    CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST =
    CW'(BLANK_CYCLES - 1);

  scan_state_t   state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    idx, idx_nxt;
  disp_word_t    cap, cap_nxt;
  disp_word_t    sel;
  logic [7:0]    an_nxt, cat_nxt, dec_w;
  logic          fs_nxt;
  logic          armed;

  always_comb begin
    sel = '0;
    case (idx)
      3'd0:    sel = d1;
      3'd1:    sel = d2;
      3'd2:    sel = d3;
      3'd3:    sel = d4;
      3'd4:    sel = d5;
      3'd5:    sel = d6;
      3'd6:    sel = d7;
      default: sel = d8;
    endcase
  end

  seg7_decoder u_dec (
    .digit (cap_nxt.digit),
    .dp_n  (cap_nxt.dp_n),
    .cat   (dec_w)
  );

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cap_nxt   = cap;
    cnt_nxt   = (cnt == SLOT_LAST) ? '0
                                   : cnt + CW'(1);
    case (state)
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          cap_nxt   = sel;
          state_nxt = DRIVE;
        end
      end
      default: begin
        if (cnt == SLOT_LAST) begin
          idx_nxt   = idx + 3'd1;
          state_nxt = BLANK;
        end
      end
    endcase
    // Outputs follow the next state so they switch
    // on the same edge as the phase change.
    an_nxt  = AN_OFF;
    cat_nxt = SEG_BLANK;
    if (state_nxt == DRIVE && cap_nxt.en) begin
      an_nxt  = ~(8'h01 << idx_nxt);
      cat_nxt = dec_w;
    end
    fs_nxt = armed ||
             (state == DRIVE && state_nxt == BLANK &&
              idx_nxt == 3'd0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= BLANK;
      cnt         <= '0;
      idx         <= '0;
      cap         <= 6'b000001;
      an          <= AN_OFF;
      dec_cat     <= SEG_BLANK;
      frame_start <= 1'b0;
      armed       <= 1'b1;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      idx         <= idx_nxt;
      cap         <= cap_nxt;
      an          <= an_nxt;
      dec_cat     <= cat_nxt;
      frame_start <= fs_nxt;
      armed       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_display_scan_driver.sv
// Randomized bench for display_scan_driver against a
// cycle-count reference model of the scan.
module tb_display_scan_driver;

  localparam int S     = 10;
  localparam int B     = 2;
  localparam int FRAME = 8 * S;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] dw [8];
  logic [7:0] an, dec_cat;
  logic       frame_start;

  int total = 0;
  int bad   = 0;
  int n     = 0;
  logic [5:0] snap [8];

  logic [6:0] seg_ref [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
    7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  always #5 clock = ~clock;

  display_scan_driver #(
    .SLOT_CYCLES  (S),
    .BLANK_CYCLES (B)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .d1          (dw[0]),
    .d2          (dw[1]),
    .d3          (dw[2]),
    .d4          (dw[3]),
    .d5          (dw[4]),
    .d6          (dw[5]),
    .d7          (dw[6]),
    .d8          (dw[7]),
    .an          (an),
    .dec_cat     (dec_cat),
    .frame_start (frame_start)
  );

  // n = clock edges since reset release; the word for
  // a slot is whatever sits on its input at the edge
  // that ends that slot's blank phase.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      n <= 0;
    end else begin
      if (n % S == B - 1)
        snap[(n / S) % 8] <= dw[(n / S) % 8];
      n <= n + 1;
    end
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s n=%0d got=%h exp=%h",
               tag, n, got, exp);
    end
  endtask

  function automatic logic [15:0] expect_out(int k);
    int         c = k % S;
    int         s = (k / S) % 8;
    logic [5:0] w = snap[s];
    logic [7:0] a;
    if (c < B || !w[5]) return 16'hFFFF;
    a = 8'h01 << s;
    return {~a, w[0], seg_ref[w[4:1]]};
  endfunction

  task automatic tick();
    logic [15:0] e;
    @(negedge clock);
    if (!reset) begin
      e = expect_out(n);
      chk("an", {24'd0, an}, {24'd0, e[15:8]});
      chk("cat", {24'd0, dec_cat}, {24'd0, e[7:0]});
      chk("fs", {31'd0, frame_start},
          {31'd0, n == 1 || (n > 0 && n % FRAME == 0)});
      chk("onehot", {31'd0, $countones(~an) <= 1},
          32'd1);
    end
  endtask

  task automatic wait_mod(int k);
    int g = 0;
    while (n % FRAME != k && g < 2 * FRAME) begin
      tick();
      g++;
    end
    if (n % FRAME != k) begin
      total++;
      bad++;
      $display("FAIL timeout n=%0d want=%0d", n, k);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) dw[i] = 6'd0;
    for (int i = 0; i < 8; i++) snap[i] = 6'd1;
    repeat (3) @(negedge clock);
    chk("rst_an", {24'd0, an}, 32'hFF);
    chk("rst_cat", {24'd0, dec_cat}, 32'hFF);
    chk("rst_fs", {31'd0, frame_start}, 32'd0);

    // only the rightmost digit lit
    dw[0] = 6'b1_0000_1;
    reset = 1'b0;
    tick();
    chk("first_fs", {31'd0, frame_start}, 32'd1);
    wait_mod(2);
    chk("t1_an", {24'd0, an}, 32'hFE);
    chk("t1_cat", {24'd0, dec_cat}, 32'hC0);
    wait_mod(15);
    chk("t1_dark", {24'd0, an}, 32'hFF);
    repeat (2 * FRAME) tick();

    // digits 1..8 everywhere
    for (int i = 0; i < 8; i++)
      dw[i] = {1'b1, 4'(i + 1), 1'b1};
    repeat (2 * FRAME) tick();
    wait_mod(41);
    chk("t2_blank", {24'd0, an}, 32'hFF);
    wait_mod(45);
    chk("t2_an", {24'd0, an}, 32'hEF);
    chk("t2_cat", {24'd0, dec_cat}, 32'h92);

    // F with decimal point on slot 3
    dw[3] = 6'b1_1111_0;
    repeat (FRAME) tick();
    wait_mod(35);
    chk("t3_an", {24'd0, an}, 32'hF7);
    chk("t3_cat", {24'd0, dec_cat}, 32'h0E);

    // mid-drive change only shows next frame
    dw[1] = {1'b1, 4'd5, 1'b1};
    repeat (FRAME) tick();
    wait_mod(15);
    dw[1] = {1'b1, 4'd9, 1'b1};
    wait_mod(17);
    chk("t4_hold", {24'd0, dec_cat}, 32'h92);
    wait_mod(15);
    chk("t4_next", {24'd0, dec_cat}, 32'h90);

    // asynchronous reset mid-slot
    wait_mod(65);
    reset = 1'b1;
    #1;
    chk("t5_an", {24'd0, an}, 32'hFF);
    chk("t5_cat", {24'd0, dec_cat}, 32'hFF);
    chk("t5_fs", {31'd0, frame_start}, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("t5_restart_fs", {31'd0, frame_start}, 32'd1);
    chk("t5_restart_an", {24'd0, an}, 32'hFF);

    // random words changing at random times
    for (int i = 0; i < 8; i++) dw[i] = 6'($urandom);
    repeat (600 * FRAME) begin
      tick();
      if ($urandom_range(0, 15) == 0)
        dw[$urandom_range(0, 7)] = 6'($urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
